// File: rtl/alarm_bank_if.sv
// Bundle of time, write, control and status signals between the clock top and alarm_bank.
// The top drives through the master modport; alarm_bank is the slave.
interface alarm_bank_if #(
    parameter int N_ALARM = 4
);
    localparam int IDX_W = (N_ALARM > 1) ? $clog2(N_ALARM) : 1;

    logic               tick;
    logic [7:0]         q_h;
    logic [7:0]         q_m;
    logic [7:0]         q_s;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [7:0]         wr_h;
    logic [7:0]         wr_m;
    logic               wr_arm;
    logic               ack;
    logic               snooze;
    logic               ring;
    logic [IDX_W-1:0]   ring_idx;
    logic [N_ALARM-1:0] armed;
    logic               bad_wr;

    modport master (
        output tick, q_h, q_m, q_s, wr_en, wr_idx, wr_h, wr_m, wr_arm, ack, snooze,
        input  ring, ring_idx, armed, bad_wr
    );

    modport slave (
        input  tick, q_h, q_m, q_s, wr_en, wr_idx, wr_h, wr_m, wr_arm, ack, snooze,
        output ring, ring_idx, armed, bad_wr
    );
endinterface

// File: rtl/alarm_bank.sv
// Multi-channel BCD hh:mm alarm unit: match on the minute boundary, bounded ring time,
// acknowledge and snooze. RING only gates the tone generator in the top level.
module alarm_bank #(
    parameter int N_ALARM    = 4,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_MIN = 5
) (
    input logic         clk,
    input logic         rst,
    alarm_bank_if.slave bus
);
    localparam int IDX_W = (N_ALARM > 1) ? $clog2(N_ALARM) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZED = 2'd2
    } state_t;

    function automatic logic bcd_ok(input logic [7:0] b, input logic [7:0] max_v);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (b <= max_v);
    endfunction

    // Time plus SNOOZE_MIN minutes, wrapping minute into hour and hour at midnight.
    function automatic logic [15:0] add_snooze(input logic [7:0] h, input logic [7:0] m);
        logic [6:0] hb;
        logic [6:0] mb;
        hb = (7'd10 * {3'd0, h[7:4]}) + {3'd0, h[3:0]};
        mb = (7'd10 * {3'd0, m[7:4]}) + {3'd0, m[3:0]} + 7'(SNOOZE_MIN);
        if (mb >= 7'd60) begin
            mb = mb - 7'd60;
            hb = (hb >= 7'd23) ? 7'd0 : hb + 7'd1;
        end
        return {4'(hb / 7'd10), 4'(hb % 7'd10), 4'(mb / 7'd10), 4'(mb % 7'd10)};
    endfunction

    logic [7:0]         alarm_h_r [N_ALARM];
    logic [7:0]         alarm_m_r [N_ALARM];
    logic [N_ALARM-1:0] armed_r;
    logic               bad_wr_r;
    state_t             state_r;
    logic               ring_r;
    logic [IDX_W-1:0]   ring_idx_r;
    logic [7:0]         cnt_r;
    logic [15:0]        target_r;

    logic               wr_valid_s;
    logic               wr_ok_s;
    logic               sec_edge_s;
    logic [N_ALARM-1:0] match_s;
    logic               hit_s;
    logic [IDX_W-1:0]   win_s;
    logic               tgt_hit_s;
    logic               disarm_s;

    // Write validation, minute-boundary matching and lowest-index winner selection.
    always_comb begin
        wr_valid_s = ({{(32-IDX_W){1'b0}}, bus.wr_idx} < N_ALARM)
                     && bcd_ok(bus.wr_h, 8'h23) && bcd_ok(bus.wr_m, 8'h59);
        wr_ok_s    = bus.wr_en && wr_valid_s;
        sec_edge_s = bus.tick && (bus.q_s == 8'h00)
                     && bcd_ok(bus.q_h, 8'h23) && bcd_ok(bus.q_m, 8'h59);
        match_s = '0;
        win_s   = '0;
        for (int i = N_ALARM - 1; i >= 0; i--) begin
            match_s[i] = sec_edge_s && armed_r[i]
                         && (alarm_h_r[i] == bus.q_h) && (alarm_m_r[i] == bus.q_m);
            win_s      = match_s[i] ? IDX_W'(i) : win_s;
        end
        hit_s     = |match_s;
        tgt_hit_s = sec_edge_s && ({bus.q_h, bus.q_m} == target_r);
        disarm_s  = wr_ok_s && !bus.wr_arm && (bus.wr_idx == ring_idx_r);
    end

    // Alarm register file, arm flags and rejected-write pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed_r  <= '0;
            bad_wr_r <= 1'b0;
            for (int i = 0; i < N_ALARM; i++) begin
                alarm_h_r[i] <= 8'h00;
                alarm_m_r[i] <= 8'h00;
            end
        end else begin
            bad_wr_r <= bus.wr_en && !wr_valid_s;
            if (wr_ok_s) begin
                alarm_h_r[bus.wr_idx] <= bus.wr_h;
                alarm_m_r[bus.wr_idx] <= bus.wr_m;
                armed_r[bus.wr_idx]   <= bus.wr_arm;
            end
        end
    end

    // Ring/snooze state machine; ACK beats SNOOZE beats tick events beats a disarming write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            ring_r     <= 1'b0;
            ring_idx_r <= '0;
            cnt_r      <= 8'd0;
            target_r   <= 16'h0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (hit_s) begin
                        state_r    <= ST_RINGING;
                        ring_r     <= 1'b1;
                        ring_idx_r <= win_s;
                        cnt_r      <= 8'd0;
                    end
                end
                ST_RINGING: begin
                    if (bus.ack) begin
                        state_r <= ST_IDLE;
                        ring_r  <= 1'b0;
                    end else if (bus.snooze) begin
                        state_r  <= ST_SNOOZED;
                        ring_r   <= 1'b0;
                        target_r <= add_snooze(bus.q_h, bus.q_m);
                    end else if ((bus.tick && (cnt_r == 8'(RING_SEC - 1))) || disarm_s) begin
                        state_r <= ST_IDLE;
                        ring_r  <= 1'b0;
                    end else if (bus.tick) begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ST_SNOOZED: begin
                    if (bus.ack) begin
                        state_r <= ST_IDLE;
                    end else if (hit_s) begin
                        // A fresh alarm match replaces the pending snooze.
                        state_r    <= ST_RINGING;
                        ring_r     <= 1'b1;
                        ring_idx_r <= win_s;
                        cnt_r      <= 8'd0;
                    end else if (tgt_hit_s) begin
                        state_r <= ST_RINGING;
                        ring_r  <= 1'b1;
                        cnt_r   <= 8'd0;
                    end else if (disarm_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ring_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ring     = ring_r;
    assign bus.ring_idx = ring_idx_r;
    assign bus.armed    = armed_r;
    assign bus.bad_wr   = bad_wr_r;
endmodule

// File: tb/tb_alarm_bank.sv
// Self-checking bench for alarm_bank: directed vector table, hand sequences for ring timeout
// and async reset, then random traffic against a minutes-of-day reference model.
module tb_alarm_bank;
    localparam int NA = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    alarm_bank_if #(.N_ALARM(NA)) bus ();
    alarm_bank #(.N_ALARM(NA), .RING_SEC(60), .SNOOZE_MIN(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic       wr_en;
        logic [1:0] wr_idx;
        logic [7:0] wr_h;
        logic [7:0] wr_m;
        logic       wr_arm;
        logic       tick;
        logic [7:0] q_h;
        logic [7:0] q_m;
        logic [7:0] q_s;
        logic       ack;
        logic       snooze;
        logic       e_ring;
        logic [1:0] e_idx;
        logic [3:0] e_armed;
        logic       e_bad;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t v(logic we, logic [1:0] wi, logic [7:0] wh, logic [7:0] wm, logic wa,
                               logic tk, logic [7:0] qh, logic [7:0] qm, logic [7:0] qs,
                               logic ak, logic sn, logic er, logic [1:0] ei, logic [3:0] ea, logic eb);
        vec_t r;
        r.wr_en = we; r.wr_idx = wi; r.wr_h = wh; r.wr_m = wm; r.wr_arm = wa;
        r.tick = tk; r.q_h = qh; r.q_m = qm; r.q_s = qs; r.ack = ak; r.snooze = sn;
        r.e_ring = er; r.e_idx = ei; r.e_armed = ea; r.e_bad = eb;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.tick = 1'b0; bus.wr_en = 1'b0; bus.ack = 1'b0; bus.snooze = 1'b0; bus.wr_arm = 1'b0;
    endtask

    task automatic apply(input vec_t r, input int n);
        bus.wr_en = r.wr_en; bus.wr_idx = r.wr_idx; bus.wr_h = r.wr_h; bus.wr_m = r.wr_m;
        bus.wr_arm = r.wr_arm; bus.tick = r.tick; bus.q_h = r.q_h; bus.q_m = r.q_m;
        bus.q_s = r.q_s; bus.ack = r.ack; bus.snooze = r.snooze;
        @(posedge clk); #1;
        chk($sformatf("row%0d.ring", n), bus.ring, r.e_ring);
        chk($sformatf("row%0d.ring_idx", n), bus.ring_idx, r.e_idx);
        chk($sformatf("row%0d.armed", n), bus.armed, r.e_armed);
        chk($sformatf("row%0d.bad_wr", n), bus.bad_wr, r.e_bad);
        idle_inputs();
    endtask

    // ---------------- reference model (times as minutes of day) ----------------
    int m_amin [NA];
    bit [3:0] m_arm;
    int m_mode;   // 0 idle, 1 ringing, 2 snoozed
    int m_idx;
    int m_cnt;
    int m_tgt;
    bit m_bad;

    function automatic int bcd2int(input logic [7:0] b);
        if (b[7:4] > 4'd9 || b[3:0] > 4'd9) return -1;
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] int2bcd(input int x);
        return {4'(x / 10), 4'(x % 10)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NA; i++) m_amin[i] = 0;
        m_arm = '0; m_mode = 0; m_idx = 0; m_cnt = 0; m_tgt = 0; m_bad = 1'b0;
    endtask

    task automatic model_step();
        int h, m, now, win, wh, wm;
        bit tvalid, sec0, wvalid, disarm;
        h = bcd2int(bus.q_h); m = bcd2int(bus.q_m);
        tvalid = (h >= 0) && (h <= 23) && (m >= 0) && (m <= 59);
        sec0 = bus.tick && (bus.q_s == 8'h00) && tvalid;
        now = h * 60 + m;
        win = -1;
        if (sec0) for (int i = NA - 1; i >= 0; i--) if (m_arm[i] && m_amin[i] == now) win = i;
        wh = bcd2int(bus.wr_h); wm = bcd2int(bus.wr_m);
        wvalid = (wh >= 0) && (wh <= 23) && (wm >= 0) && (wm <= 59);
        m_bad = bus.wr_en && !wvalid;
        disarm = bus.wr_en && wvalid && !bus.wr_arm && (int'(bus.wr_idx) == m_idx);
        if (m_mode == 0) begin
            if (win >= 0) begin m_mode = 1; m_idx = win; m_cnt = 0; end
        end else if (m_mode == 1) begin
            if (bus.ack) m_mode = 0;
            else if (bus.snooze) begin m_mode = 2; m_tgt = (now + 5) % 1440; end
            else begin
                if (bus.tick) begin m_cnt++; if (m_cnt >= 60) m_mode = 0; end
                if (m_mode == 1 && disarm) m_mode = 0;
            end
        end else begin
            if (bus.ack) m_mode = 0;
            else if (win >= 0) begin m_mode = 1; m_idx = win; m_cnt = 0; end
            else if (sec0 && now == m_tgt) begin m_mode = 1; m_cnt = 0; end
            else if (disarm) m_mode = 0;
        end
        if (bus.wr_en && wvalid) begin
            m_amin[bus.wr_idx] = wh * 60 + wm;
            m_arm[bus.wr_idx] = bus.wr_arm;
        end
    endtask

    initial begin
        int pool [5];
        int t_sec, r, mm;
        bit q_ok;
        pool = '{7 * 60 + 30, 12 * 60, 23 * 60 + 58, 23 * 60 + 59, 3};
        idle_inputs();
        bus.wr_idx = 2'd0; bus.wr_h = 8'h00; bus.wr_m = 8'h00;
        bus.q_h = 8'h00; bus.q_m = 8'h00; bus.q_s = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset.ring", bus.ring, 1'b0);
        chk("reset.ring_idx", bus.ring_idx, 2'd0);
        chk("reset.armed", bus.armed, 4'b0000);
        chk("reset.bad_wr", bus.bad_wr, 1'b0);
        @(negedge clk); rst = 1'b0;

        //            we wi wh     wm     wa tk qh     qm     qs     ak sn  er ei ea       eb
        tbl.push_back(v(1, 2, 8'h07, 8'h30, 1, 0, 8'h07, 8'h29, 8'h59, 0, 0, 0, 0, 4'b0100, 0));
        tbl.push_back(v(0, 0, 8'h00, 8'h00, 0, 1, 8'h07, 8'h29, 8'h59, 0, 0, 0, 0, 4'b0100, 0));
        tbl.push_back(v(0, 0, 8'h00, 8'h00, 0, 1, 8'h07, 8'h30, 8'h00, 0, 0, 1, 2, 4'b0100, 0));
        tbl.push_back(v(1, 1, 8'h24, 8'h00, 1, 0, 8'h07, 8'h30, 8'h00, 0, 0, 1, 2, 4'b0100, 1));
        tbl.push_back(v(1, 1, 8'h10, 8'h5A, 1, 0, 8'h07, 8'h30, 8'h00, 0, 0, 1, 2, 4'b0100, 1));
        tbl.push_back(v(0, 0, 8'h00, 8'h00, 0, 0, 8'h07, 8'h30, 8'h00, 0, 0, 1, 2, 4'b0100, 0));
        tbl.push_back(v(0, 0, 8'h00, 8'h00, 0, 0, 8'h07, 8'h30, 8'h00, 1, 0, 0, 2, 4'b0100, 0));
        tbl.push_back(v(1, 0, 8'h12, 8'h00, 1, 0, 8'h07, 8'h30, 8'h00, 0, 0, 0, 2, 4'b0101, 0));
        tbl.push_back(v(1, 3, 8'h12, 8'h00, 1, 0, 8'h07, 8'h30, 8'h00, 0, 0, 0, 2, 4'b1101, 0));
        tbl.push_back(v(0, 0, 8'h00, 8'h00, 0, 1, 8'h12, 8'h00, 8'h05, 0, 0, 0, 2, 4'b1101, 0));
        tbl.push_back(v(0, 0, 8'h00, 8'h00, 0, 1, 8'h12, 8'h00, 8'h00, 0, 0, 1, 0, 4'b1101, 0));
        // after the 60-tick timeout sequence
        tbl.push_back(v(1, 1, 8'h23, 8'h58, 1, 0, 8'h12, 8'h01, 8'h00, 0, 0, 0, 0, 4'b1111, 0));
        tbl.push_back(v(0, 0, 8'h00, 8'h00, 0, 1, 8'h23, 8'h58, 8'h00, 0, 0, 1, 1, 4'b1111, 0));
        tbl.push_back(v(0, 0, 8'h00, 8'h00, 0, 0, 8'h23, 8'h58, 8'h00, 0, 1, 0, 1, 4'b1111, 0));
        tbl.push_back(v(0, 0, 8'h00, 8'h00, 0, 1, 8'h00, 8'h02, 8'h00, 0, 0, 0, 1, 4'b1111, 0));
        tbl.push_back(v(0, 0, 8'h00, 8'h00, 0, 1, 8'h00, 8'h03, 8'h00, 0, 0, 1, 1, 4'b1111, 0));
        tbl.push_back(v(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h03, 8'h00, 1, 0, 0, 1, 4'b1111, 0));
        tbl.push_back(v(0, 0, 8'h00, 8'h00, 0, 1, 8'h23, 8'h58, 8'h00, 0, 0, 1, 1, 4'b1111, 0));
        tbl.push_back(v(0, 0, 8'h00, 8'h00, 0, 0, 8'h23, 8'h58, 8'h00, 1, 1, 0, 1, 4'b1111, 0));
        tbl.push_back(v(0, 0, 8'h00, 8'h00, 0, 1, 8'h00, 8'h03, 8'h00, 0, 0, 0, 1, 4'b1111, 0));
        tbl.push_back(v(0, 0, 8'h00, 8'h00, 0, 1, 8'h23, 8'h58, 8'h00, 0, 0, 1, 1, 4'b1111, 0));
        tbl.push_back(v(1, 1, 8'h23, 8'h58, 0, 0, 8'h23, 8'h58, 8'h00, 0, 0, 0, 1, 4'b1101, 0));
        tbl.push_back(v(0, 0, 8'h00, 8'h00, 0, 1, 8'h12, 8'h00, 8'h00, 0, 0, 1, 0, 4'b1101, 0));

        for (int i = 0; i < 11; i++) apply(tbl[i], i);

        // Unacknowledged ring drops on the 60th TICK after it started
        for (int k = 1; k <= 60; k++) begin
            bus.tick = 1'b1;
            bus.q_h = 8'h12;
            bus.q_m = (k == 60) ? 8'h01 : 8'h00;
            bus.q_s = (k == 60) ? 8'h00 : int2bcd(k);
            @(posedge clk); #1;
            bus.tick = 1'b0;
            chk($sformatf("timeout.tick%0d", k), bus.ring, (k < 60) ? 1'b1 : 1'b0);
        end

        for (int i = 11; i < tbl.size(); i++) apply(tbl[i], i);

        // Asynchronous reset between clock edges while ringing
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("async_rst.ring", bus.ring, 1'b0);
        chk("async_rst.armed", bus.armed, 4'b0000);
        chk("async_rst.ring_idx", bus.ring_idx, 2'd0);
        @(negedge clk); rst = 1'b0;

        // Random traffic against the reference model
        model_reset();
        t_sec = 0; q_ok = 1'b1;
        bus.q_h = 8'h00; bus.q_m = 8'h00; bus.q_s = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            bus.tick = ($urandom_range(0, 1) == 1);
            if (bus.tick) begin
                r = $urandom_range(0, 9);
                if (r < 4) t_sec = pool[$urandom_range(0, 4)] * 60;
                else if (r == 4 && m_mode == 2) t_sec = m_tgt * 60;
                else t_sec = (t_sec + $urandom_range(1, 90)) % 86400;
                bus.q_h = int2bcd(t_sec / 3600);
                bus.q_m = int2bcd((t_sec / 60) % 60);
                bus.q_s = int2bcd(t_sec % 60);
                q_ok = 1'b1;
                if ($urandom_range(0, 29) == 0) begin
                    bus.q_m = 8'h6A;
                    q_ok = 1'b0;
                end
            end
            bus.ack = ($urandom_range(0, 24) == 0);
            bus.snooze = (m_mode == 1) && q_ok && ($urandom_range(0, 7) == 0);
            bus.wr_en = ($urandom_range(0, 9) == 0);
            bus.wr_idx = 2'($urandom_range(0, 3));
            mm = pool[$urandom_range(0, 4)];
            bus.wr_h = int2bcd(mm / 60);
            bus.wr_m = int2bcd(mm % 60);
            bus.wr_arm = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 9))
                0: bus.wr_h = 8'h24;
                1: bus.wr_m = 8'h5A;
                2: bus.wr_h = 8'h1F;
                default: ;
            endcase
            model_step();
            @(posedge clk); #1;
            chk("rnd.ring", bus.ring, (m_mode == 1) ? 1'b1 : 1'b0);
            chk("rnd.ring_idx", bus.ring_idx, m_idx);
            chk("rnd.armed", bus.armed, m_arm);
            chk("rnd.bad_wr", bus.bad_wr, m_bad);
        end
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
